// File: rtl/mac_stream_issuer.sv
// Valid/ready shell around a fixed-latency fused multiply-add core: issues operands,
// tracks in-flight ops, and queues results in order. Optional counters: MAC_ISSUER_PERF_EN.
module mac_stream_issuer #(
  parameter int LATENCY = 9,
  parameter int DEPTH   = 16,
  parameter int W       = 32
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         ivalid,
  output logic         oready,
  input  logic [W-1:0] datainA,
  input  logic [W-1:0] datainB,
  input  logic [W-1:0] datainC,
  output logic [W-1:0] mac_a,
  output logic [W-1:0] mac_b,
  output logic [W-1:0] mac_c,
  input  logic [W-1:0] mac_q,
  output logic         ovalid,
  input  logic         iready,
  output logic [W-1:0] dataout
`ifdef MAC_ISSUER_PERF_EN
  ,
  output logic [31:0]  perf_issued,
  output logic [31:0]  perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic               accept;
  logic               pop;
  logic [PW-1:0]      occ_q, occ_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LATENCY-1:0] vpipe_q, vpipe_d;
  logic               wr_en_q;
  logic [W-1:0]       mac_a_q, mac_a_d;
  logic [W-1:0]       mac_b_q, mac_b_d;
  logic [W-1:0]       mac_c_q, mac_c_d;
  logic               ovalid_q, ovalid_d;
  logic [W-1:0]       dataout_q, dataout_d;
  logic [W-1:0]       fifo_mem [DEPTH];

  // Credits cover both in-flight ops and stored results, so the FIFO cannot overflow.
  assign oready  = (occ_q < PW'(DEPTH));
  assign accept  = ivalid & oready;
  assign pop     = ovalid_q & iready;

  assign mac_a   = mac_a_q;
  assign mac_b   = mac_b_q;
  assign mac_c   = mac_c_q;
  assign ovalid  = ovalid_q;
  assign dataout = dataout_q;

  always_comb begin
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_c_d   = mac_c_q;
    occ_d     = occ_q;
    dataout_d = dataout_q;
    if (accept) begin
      mac_a_d = datainA;
      mac_b_d = datainB;
      mac_c_d = datainC;
    end
    vpipe_d = {vpipe_q[LATENCY-2:0], accept};
    if (accept && !pop) begin
      occ_d = occ_q + PW'(1);
    end else if (!accept && pop) begin
      occ_d = occ_q - PW'(1);
    end
    wr_ptr_d = wr_ptr_q + PW'(wr_en_q);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovalid_d = (wr_ptr_d != rd_ptr_d);
    // The head register follows the new read pointer; take mac_q when that slot is written now.
    if (wr_en_q && (rd_ptr_d == wr_ptr_q)) begin
      dataout_d = mac_q;
    end else if (rd_ptr_d != wr_ptr_q) begin
      dataout_d = fifo_mem[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_c_q   <= '0;
      vpipe_q   <= '0;
      wr_en_q   <= 1'b0;
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovalid_q  <= 1'b0;
      dataout_q <= '0;
    end else begin
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_c_q   <= mac_c_d;
      vpipe_q   <= vpipe_d;
      wr_en_q   <= vpipe_q[LATENCY-1];
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovalid_q  <= ovalid_d;
      dataout_q <= dataout_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_q) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= mac_q;
    end
  end

`ifdef MAC_ISSUER_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept) perf_issued_q <= perf_issued_q + 32'd1;
      if (ivalid && !oready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
